// File: rtl/compare_sort_sequencer_if.sv
// Stream bundle for compare_sort_sequencer: a word-in channel, a sorted-word-out
// channel and a busy status line.
interface compare_sort_sequencer_if #(
    parameter int N = 32
);
    // A word moves on a channel in every cycle where valid && ready are both high
    // at the rising clock edge. A producer holds valid and its data stable until
    // that transfer, and valid never waits on ready.
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, in_data, is_signed, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, is_signed, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/compare_sort_sequencer.sv
// Frame sorter: buffers DEPTH words, bubble-sorts them in place with one shared
// compare-and-swap per cycle (early exit), then streams them out ascending.

module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    logic eq;

    // MSB-first scan; at the sign bit a set bit means the smaller value.
    always_comb begin
        lt = 1'b0;
        eq = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            if (eq && (a[k] != b[k])) begin
                lt = (k == N - 1) ? a[k] : b[k];
            end
            eq = eq & (a[k] == b[k]);
        end
    end
endmodule

module comparator_lt_unsigned #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    logic eq;

    always_comb begin
        lt = 1'b0;
        eq = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            if (eq && (a[k] != b[k])) begin
                lt = b[k];
            end
            eq = eq & (a[k] == b[k]);
        end
    end
endmodule

module compare_sort_sequencer #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    compare_sort_sequencer_if.slave  bus,
    output logic [1:0]               state_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_CMP = AW'(DEPTH - 2);

    state_t        state_q, state_d;
    logic [N-1:0]  buf_q [DEPTH];
    logic [N-1:0]  buf_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] pass_q, pass_d;
    logic          swapped_q, swapped_d;
    logic          mode_q, mode_d;

    logic [AW-1:0] idx_nx;
    logic [N-1:0]  cmp_a, cmp_b;
    logic          lt_s, lt_u, swap_en;

    assign idx_nx = idx_q + AW'(1);
    assign cmp_a  = buf_q[idx_nx];
    assign cmp_b  = buf_q[idx_q];

    comparator_lt #(.N(N)) u_lt_s (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (lt_s)
    );

    comparator_lt_unsigned #(.N(N)) u_lt_u (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (lt_u)
    );

    // Strict less-than only, so equal neighbours keep their order.
    assign swap_en = mode_q ? lt_s : lt_u;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            mode_q    <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            mode_q    <= mode_d;
            for (int k = 0; k < DEPTH; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        mode_d    = mode_q;
        case (state_q)
            S_LOAD: begin
                if (bus.in_valid) begin
                    buf_d[wr_ptr_q] = bus.in_data;
                    wr_ptr_d        = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == '0) begin
                        mode_d = bus.is_signed;
                    end
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d   = S_SORT;
                        idx_d     = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                    end
                end
            end
            S_SORT: begin
                if (swap_en) begin
                    buf_d[idx_q]  = cmp_a;
                    buf_d[idx_nx] = cmp_b;
                end
                if (idx_q == LAST_CMP) begin
                    // The swap made on the last compare still counts for this pass.
                    idx_d     = '0;
                    pass_d    = pass_q + AW'(1);
                    swapped_d = 1'b0;
                    if (!(swapped_q || swap_en) || (pass_q == LAST_CMP)) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    idx_d     = idx_nx;
                    swapped_d = swapped_q | swap_en;
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (rd_ptr_q == LAST_IDX) begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.busy      = (state_q == S_SORT);
    assign bus.out_valid = (state_q == S_DRAIN);
    assign bus.out_last  = (state_q == S_DRAIN) && (rd_ptr_q == LAST_IDX);
    assign bus.out_data  = (state_q == S_DRAIN) ? buf_q[rd_ptr_q] : '0;
    assign state_o       = state_q;
endmodule

// File: tb/tb_compare_sort_sequencer.sv
// Directed and random frame tests for compare_sort_sequencer (N=32, DEPTH=8):
// sort latency, ordering in both compare modes, handshakes and reset.
module tb_compare_sort_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    compare_sort_sequencer_if #(.N(32)) bus ();

    compare_sort_sequencer #(.N(32), .DEPTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] frame_w [8];
    logic [31:0] ref_w   [8];
    logic [31:0] exp_q   [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_lt(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        if (sgn) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Early-exit bubble sort of frame_w; pushes the sorted words, returns passes run.
    function automatic int ref_sort(input bit sgn);
        int          passes = 0;
        bit          sw;
        logic [31:0] t;
        for (int i = 0; i < 8; i++) ref_w[i] = frame_w[i];
        for (int p = 0; p < 7; p++) begin
            sw = 1'b0;
            for (int i = 0; i < 7; i++) begin
                if (ref_lt(ref_w[i+1], ref_w[i], sgn)) begin
                    t = ref_w[i]; ref_w[i] = ref_w[i+1]; ref_w[i+1] = t;
                    sw = 1'b1;
                end
            end
            passes++;
            if (!sw) break;
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(ref_w[i]);
        return passes;
    endfunction

    task automatic send_frame(input bit sgn, input bit rnd_valid);
        int k = 0;
        int guard = 0;
        bit rdy_bad = 1'b0;
        while (k < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (!bus.in_ready) rdy_bad = 1'b1;
            bus.in_valid  = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data   = bus.in_valid ? frame_w[k] : 32'hDEAD_BEEF;
            bus.is_signed = (k == 0) ? sgn : ~sgn;
            if (bus.in_valid) k++;
        end
        check("load_count", k, 8);
        check("load_in_ready", rdy_bad, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic measure_sort(input int exp_cycles);
        int cyc = 0;
        int guard = 0;
        bit rdy_bad = 1'b0;
        while (!bus.out_valid && guard < 300) begin
            if (bus.busy) cyc++;
            if (bus.in_ready) rdy_bad = 1'b1;
            guard++;
            @(negedge clk);
        end
        check("sort_done", bus.out_valid, 1);
        check("sort_gap", guard, cyc);
        check("sort_in_ready", rdy_bad, 0);
        if (exp_cycles >= 0) check("sort_cycles", cyc, exp_cycles);
    endtask

    task automatic drain(input bit rnd_ready, input bit expect_consec);
        int          cnt = 0;
        int          guard = 0;
        bit          stalled = 1'b0;
        bit          rdy_bad = 1'b0;
        bit          gap = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] exp;
        while (cnt < 8 && guard < 300) begin
            guard++;
            bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.in_ready) rdy_bad = 1'b1;
            if (bus.out_valid) begin
                if (stalled) check("stall_hold", bus.out_data, held);
                if (bus.out_ready) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
                    check("out_data", bus.out_data, exp);
                    check("out_last", bus.out_last, (cnt == 7) ? 1 : 0);
                    cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_data;
                end
            end else begin
                gap = 1'b1;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("drain_count", cnt, 8);
        check("drain_in_ready", rdy_bad, 0);
        if (expect_consec) check("drain_gap", gap, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_out_valid", bus.out_valid, 0);
        exp_q.delete();
    endtask

    task automatic run_frame(input bit sgn, input bit rnd_v, input bit rnd_r, input int exp_cycles);
        send_frame(sgn, rnd_v);
        measure_sort(exp_cycles);
        drain(rnd_r, !rnd_r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
    endtask

    task automatic set_frame(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
        frame_w[0] = w0; frame_w[1] = w1; frame_w[2] = w2; frame_w[3] = w3;
        frame_w[4] = w4; frame_w[5] = w5; frame_w[6] = w6; frame_w[7] = w7;
    endtask

    task automatic set_exp(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
        exp_q.delete();
        exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
        exp_q.push_back(w4); exp_q.push_back(w5); exp_q.push_back(w6); exp_q.push_back(w7);
    endtask

    initial begin
        int  passes;
        bit  sgn;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Already sorted, unsigned: one pass.
        set_frame(0, 1, 2, 3, 4, 5, 6, 7);
        set_exp(0, 1, 2, 3, 4, 5, 6, 7);
        run_frame(1'b0, 1'b0, 1'b0, 7);

        // Reverse order: full seven passes.
        set_frame(7, 6, 5, 4, 3, 2, 1, 0);
        set_exp(0, 1, 2, 3, 4, 5, 6, 7);
        run_frame(1'b0, 1'b0, 1'b0, 49);

        // Same words, signed then unsigned ordering.
        set_frame(32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h7FFFFFFF,
                  32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000001);
        set_exp(32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000,
                32'h00000000, 32'h00000001, 32'h00000001, 32'h7FFFFFFF);
        run_frame(1'b1, 1'b0, 1'b0, -1);
        set_exp(32'h00000000, 32'h00000000, 32'h00000001, 32'h00000001,
                32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFF);
        run_frame(1'b0, 1'b0, 1'b0, -1);

        // Random gaps on both channels.
        set_frame(5, 3, 3, 9, 1, 0, 8, 2);
        set_exp(0, 1, 2, 3, 3, 5, 8, 9);
        run_frame(1'b0, 1'b1, 1'b1, -1);

        // Reset in the middle of SORT discards the frame.
        set_frame(7, 6, 5, 4, 3, 2, 1, 0);
        send_frame(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_sort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        set_frame(0, 1, 2, 3, 4, 5, 6, 7);
        set_exp(0, 1, 2, 3, 4, 5, 6, 7);
        run_frame(1'b0, 1'b0, 1'b0, 7);

        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 8; i++) frame_w[i] = $urandom;
            if (f % 10 == 0) frame_w[3] = frame_w[6];
            sgn = 1'($urandom_range(0, 1));
            exp_q.delete();
            passes = ref_sort(sgn);
            run_frame(sgn, 1'(f % 3 == 0), 1'(f % 4 == 1), passes * 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
